led_arbiter: RTL and testbench
==============================

# led_arbiter

Round-robin arbiter that shares the Alhambra-II 8-LED bank between up to eight independent requesters. Each requester raises a request and presents an 8-bit pattern. The arbiter grants one owner at a time and drives the owner's pattern onto the LEDs. It sits between application blocks (counters, debug monitors, demos) and the board-level `leds` driver.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `HOLD_MAX`, default 1200000: maximum ownership cycles under contention (100 ms at 12 MHz); legal range 2..2^24-1. Used only with `LED_ARB_TIMEOUT_EN`.

**Ports** (clock and reset first)
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `req`, input, `N_REQ`: per-requester request level.
- `pat`, input, `8*N_REQ`: patterns; requester i drives `pat[8*i+7:8*i]`.
- `gnt`, output, `N_REQ`: one-hot grant, registered.
- `owner`, output, 3: index of the current owner; holds the last owner when idle.
- `busy`, output, 1: high while in GRANT.
- `leds`, output, 8: LED bank drive; bit k maps to LEDk.

## Operation

**Reset** (synchronous, takes effect on the next edge, including mid-grant):
- `leds`=0, `gnt`=0, `owner`=0, `busy`=0.
- State=IDLE, round-robin pointer `ptr`=0, hold counter=0.

**States**
- **IDLE**: `gnt`=0, `leds`=0.
  - If `req`≠0, select the first asserted request scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - At that edge: set `owner`, set `gnt` one-hot, load `leds` with the winner's `pat` slice, clear the counter, go to GRANT.
- **GRANT**:
  - Each edge, `leds` <= `pat[owner]` (live pattern updates).
  - If `req[owner]`=0, go to GAP.
- **GAP**: exactly one cycle with `gnt`=0 and `leds`=0.
  - `ptr` <= (`owner`+1) mod `N_REQ`.
  - Next state is IDLE.

**Boundary rules**
- The owner may drop `req` at any cycle, including its first granted cycle.
- After release, the same requester regains the bank only if no other request is pending when IDLE scans from `ptr`.
- Requests from index ≥ `N_REQ` do not exist; `owner` never exceeds `N_REQ`-1.
- `pat` of non-owners is ignored.
- Release and timeout in the same cycle are treated as a release; the result is identical (GAP, `ptr` advances).

## Timing

- `req` rising, sampled at edge E0 in IDLE: `gnt`/`busy`/`leds` valid after E0 (1-cycle latency).
- Pattern change while granted: reflected on `leds` after the next edge (1-cycle latency).
- `req[owner]` low, sampled at edge E1: `gnt`=0 and `leds`=0 after E1 (GAP), IDLE after E1+1, next grant after E1+2 at the earliest.
- Minimum dead time between two owners: 2 cycles (GAP plus IDLE).
- `busy` equals (state==GRANT); `gnt` is never asserted outside GRANT.

## Configuration

- **`LED_ARB_TIMEOUT_EN` defined**:
  - A 24-bit hold counter increments each GRANT cycle and saturates at `HOLD_MAX`-1.
  - If the counter equals `HOLD_MAX`-1 and any other `req` bit is high, the arbiter preempts to GAP (`ptr` advances) even though `req[owner]` is still high.
  - With no competing request, the owner keeps the bank indefinitely.
- **Not defined**: no counter logic is synthesized, and ownership ends only when the owner drops `req`. `HOLD_MAX` is ignored.

## Test plan

- **Reset**: `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `leds`=0, `busy`=0. One cycle after `rst` falls → `gnt`=4'b0001, `leds`=`pat[7:0]`.
- **Single request**: `req`=4'b0100, `pat[23:16]`=8'hA5 → after 1 edge `gnt`=4'b0100, `owner`=2, `leds`=8'hA5. Change the pattern to 8'h3C → `leds`=8'h3C one edge later.
- **Round-robin**: hold `req`=4'b1011, and each owner drops its `req` 3 cycles after its grant, then re-raises it. Required order: owners 0, 1, 3, 0. Each handover shows exactly one `leds`=0 GAP cycle, and two cycles separate successive grants.
- **Mid-grant reset**: owner 1 granted, assert `rst` for 1 cycle → next edge all outputs 0. After release, `req`=4'b0011 grants owner 0 (`ptr` was reset).
- **Timeout** (`LED_ARB_TIMEOUT_EN`, `HOLD_MAX`=8): owner 0 holds `req`, and `req[2]` rises at grant+2 → preemption to GAP after the 8th GRANT cycle, then `gnt`=4'b0100. Owner 0 alone for 20 cycles → no preemption.
- **No timeout** (macro undefined, same stimulus as the timeout test) → owner 0 keeps `gnt` until its `req` drops.

Source files
------------

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing the 8-LED bank between up to eight requesters.
// Define LED_ARB_TIMEOUT_EN to enable hold-time preemption under contention.
module led_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_MAX = 1200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   pat,
    output logic [N_REQ-1:0]     gnt,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic [7:0]           leds
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("led_arbiter: N_REQ must be in 2..8");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 32'hFF_FFFF) begin : g_bad_hold_max
        $error("led_arbiter: HOLD_MAX must be in 2..2^24-1");
    end

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       leds_q, leds_d;

    logic             win_valid;
    logic [2:0]       win_idx;
    logic [7:0]       win_pat;
    logic             own_req;
    logic [7:0]       own_pat;
    logic             preempt;

    // Descending scans leave the lowest matching index, first from ptr upward, then wrapped.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (3'(i) >= ptr_q)) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
            end
        end
        if (!win_valid) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_valid = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        win_pat = '0;
        own_req = 1'b0;
        own_pat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_pat = pat[8*i +: 8];
            end
            if (owner_q == 3'(i)) begin
                own_req = req[i];
                own_pat = pat[8*i +: 8];
            end
        end
    end

`ifdef LED_ARB_TIMEOUT_EN
    localparam logic [23:0] HoldLast = 24'(HOLD_MAX - 1);

    logic [23:0] hold_q, hold_d;
    logic        others;

    // gnt_q is the owner's one-hot while granted, so this masks out the owner.
    assign others = |(req & ~gnt_q);

    always_comb begin
        hold_d = hold_q;
        if (state_q == StIdle) begin
            hold_d = '0;
        end else if (state_q == StGrant && hold_q != HoldLast) begin
            hold_d = hold_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign preempt = (hold_q == HoldLast) && others;
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            leds_q  <= leds_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        leds_d  = leds_q;
        unique case (state_q)
            StIdle: begin
                gnt_d  = '0;
                leds_d = '0;
                if (win_valid) begin
                    state_d = StGrant;
                    owner_d = win_idx;
                    leds_d  = win_pat;
                    for (int i = 0; i < N_REQ; i++) begin
                        gnt_d[i] = (win_idx == 3'(i));
                    end
                end
            end
            StGrant: begin
                // A release in the same cycle as a timeout lands here identically.
                if (!own_req || preempt) begin
                    state_d = StGap;
                    gnt_d   = '0;
                    leds_d  = '0;
                end else begin
                    leds_d = own_pat;
                end
            end
            StGap: begin
                state_d = StIdle;
                gnt_d   = '0;
                leds_d  = '0;
                ptr_d   = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                leds_d  = '0;
            end
        endcase
    end

    always_comb begin
        gnt   = gnt_q;
        owner = owner_q;
        leds  = leds_q;
        busy  = (state_q == StGrant);
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Randomized and directed bench for led_arbiter against a cycle-level ownership model.
module tb_led_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;
`ifdef LED_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0] pat = '0;
    logic [N-1:0]  gnt;
    logic [2:0]    owner;
    logic          busy;
    logic [7:0]    leds;

    int n_vec = 0;
    int n_err = 0;

    // Model: who owns the bank, how long they held it, and the dead time left.
    int       m_own  = -1;
    int       m_held = 0;
    int       m_cool = 0;
    int       m_ptr  = 0;
    int       m_last = 0;
    logic [7:0] m_leds = '0;

    led_arbiter #(.N_REQ(N), .HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pat   (pat),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        logic others;
        logic found;
        int   idx;
        if (rst) begin
            m_own = -1; m_held = 0; m_cool = 0; m_ptr = 0; m_last = 0; m_leds = '0;
        end else if (m_own >= 0) begin
            others = 1'b0;
            for (int k = 0; k < N; k++) if (k != m_own && req[k]) others = 1'b1;
            if (!req[m_own] || (TIMEOUT && m_held >= HOLD && others)) begin
                m_ptr  = (m_own + 1) % N;
                m_own  = -1;
                m_cool = 1;
                m_leds = '0;
            end else begin
                m_held++;
                m_leds = pat[8*m_own +: 8];
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    m_own  = idx;
                    m_last = idx;
                    m_held = 1;
                    m_leds = pat[8*idx +: 8];
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [3:0] g;
        g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
        return {g, 3'(m_last), (m_own >= 0), m_leds};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        pat = $urandom;
        tick();
        tick();
        n_vec++;
        if ({gnt, busy, leds} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_hold: gnt/busy/leds got %b/%b/%h want 0/0/00", gnt, busy, leds);
        end
        n_vec++;
        if ({gnt, owner, busy, leds} !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_model: got %h want %h", {gnt, owner, busy, leds}, exp_vec());
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (gnt !== 4'b0001 || leds !== pat[7:0] || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: gnt=%b leds=%h busy=%b want 0001/%h/1",
                     gnt, leds, busy, pat[7:0]);
        end
    endtask

    task automatic test_single();
        rst = 1'b1; req = '0; tick(); rst = 1'b0;
        pat = $urandom;
        pat[23:16] = 8'hA5;
        req = 4'b0100;
        tick();
        n_vec++;
        if (gnt !== 4'b0100 || owner !== 3'd2 || leds !== 8'hA5) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b owner=%0d leds=%h want 0100/2/a5", gnt, owner, leds);
        end
        pat[23:16] = 8'h3C;
        pat[7:0]   = 8'hFF;
        tick();
        n_vec++;
        if (leds !== 8'h3C || {gnt, owner, busy, leds} !== exp_vec()) begin
            n_err++;
            $display("FAIL single_live_pat: leds=%h want 3c", leds);
        end
    endtask

    task automatic test_round_robin();
        int   order[$];
        int   want[4] = '{0, 1, 3, 0};
        int   dead;
        logic prev_busy;
        rst = 1'b1; req = '0; tick(); rst = 1'b0;
        req = 4'b1011;
        dead = 0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 80 && order.size() < 4; cyc++) begin
            pat = $urandom;
            tick();
            n_vec++;
            if ({gnt, owner, busy, leds} !== exp_vec()) begin
                n_err++;
                $display("FAIL rr_cycle: cyc=%0d got %h want %h", cyc, {gnt, owner, busy, leds},
                         exp_vec());
            end
            if (busy && !prev_busy) begin
                order.push_back(int'(owner));
                if (order.size() > 1) begin
                    n_vec++;
                    if (dead != 2) begin
                        n_err++;
                        $display("FAIL rr_dead: dead cycles got %0d want 2", dead);
                    end
                end
            end
            dead = busy ? 0 : dead + 1;
            prev_busy = busy;
            req = 4'b1011;
            if (m_own >= 0 && m_held == 3) req[m_own] = 1'b0;
        end
        n_vec++;
        if (order.size() != 4) begin
            n_err++;
            $display("FAIL rr_count: grants got %0d want 4", order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (order[k] != want[k]) begin
                    n_err++;
                    $display("FAIL rr_order: grant %0d owner got %0d want %0d", k, order[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; req = '0; tick(); rst = 1'b0;
        req = 4'b0010;
        pat = $urandom;
        tick();
        n_vec++;
        if (gnt !== 4'b0010 || owner !== 3'd1) begin
            n_err++;
            $display("FAIL midrst_grant: gnt=%b owner=%0d want 0010/1", gnt, owner);
        end
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({gnt, owner, busy, leds} !== 16'h0) begin
            n_err++;
            $display("FAIL midrst_clear: got %h want 0000", {gnt, owner, busy, leds});
        end
        rst = 1'b0;
        req = 4'b0011;
        tick();
        n_vec++;
        if (gnt !== 4'b0001 || owner !== 3'd0 || {gnt, owner, busy, leds} !== exp_vec()) begin
            n_err++;
            $display("FAIL midrst_ptr: gnt=%b owner=%0d want 0001/0", gnt, owner);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        rst = 1'b1; req = '0; tick(); rst = 1'b0;
        pat = $urandom;
        req = 4'b0001;
        tick();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (gnt !== 4'b0001) break;
            cnt++;
            if (cnt == 2) req = 4'b0101;
            tick();
            n_vec++;
            if ({gnt, owner, busy, leds} !== exp_vec()) begin
                n_err++;
                $display("FAIL timeout_cycle: c=%0d got %h want %h", c, {gnt, owner, busy, leds},
                         exp_vec());
            end
        end
        n_vec++;
        if (cnt != (TIMEOUT ? HOLD : 40)) begin
            n_err++;
            $display("FAIL timeout_hold: owner 0 cycles got %0d want %0d", cnt, TIMEOUT ? HOLD : 40);
        end
        if (!TIMEOUT) begin
            req = 4'b0100;
            tick();
        end
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'b0100 || owner !== 3'd2) begin
            n_err++;
            $display("FAIL timeout_next: gnt=%b owner=%0d want 0100/2", gnt, owner);
        end
        // Without competition the owner must never be preempted.
        rst = 1'b1; req = '0; tick(); rst = 1'b0;
        req = 4'b0001;
        tick();
        for (int c = 0; c < 20; c++) begin
            pat = $urandom;
            tick();
        end
        n_vec++;
        if (gnt !== 4'b0001 || leds !== pat[7:0]) begin
            n_err++;
            $display("FAIL timeout_alone: gnt=%b leds=%h want 0001/%h", gnt, leds, pat[7:0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            req = 4'($urandom);
            if (m_own >= 0 && $urandom_range(0, 9) != 0) req[m_own] = 1'b1;
            pat = $urandom;
            tick();
            n_vec++;
            if ({gnt, owner, busy, leds} !== exp_vec()) begin
                n_err++;
                $display("FAIL random: c=%0d got gnt=%b owner=%0d busy=%b leds=%h want %h",
                         c, gnt, owner, busy, leds, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mid_reset();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
